// File: rtl/lag_accumulator.sv
// Per-lag multiply-accumulate stage for the correlator delay path.
// It integrates cur_data*dly_data over n_samples pairs and hands the sum to readout.
module lag_accumulator #(
   parameter int DIM   = 16,
   parameter int ACC_W = 48,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             stall,
   input  logic             start,
   input  logic [CNT_W-1:0] n_samples,
   input  logic [DIM-1:0]   cur_data,
   input  logic [DIM-1:0]   dly_data,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   count, n_lat, count_inc;
   logic [ACC_W-1:0]   acc;
   logic [2*DIM-1:0]   prod_r;
   logic               prod_vld_r;
   logic               sat;
   logic               take_start, consume, last_pair;
   logic [ACC_W:0]     sum;

   assign take_start = (state == IDLE) && start;
   assign consume    = (state == RUN) && !stall;
   assign count_inc  = count + CNT_W'(1);
   assign last_pair  = consume && (count_inc == n_lat);
   assign sum        = {1'b0, acc} + (ACC_W+1)'(prod_r);

   assign busy      = (state == RUN) || (state == DRAIN);
   // Result handshake: out_valid holds in DONE with out_acc/out_count/out_sat
   // stable; a cycle with out_valid & out_ready transfers the result and returns to IDLE.
   assign out_valid = (state == DONE);
   assign out_acc   = acc;
   assign out_count = count;
   assign out_sat   = sat;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (n_samples == '0) ? DONE : RUN;
         RUN:     if (last_pair) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Multiply stage runs only on consumed pairs; the accumulate stage follows
   // prod_vld_r alone so the final product lands during DRAIN regardless of stall.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         n_lat      <= '0;
         count      <= '0;
         acc        <= '0;
         prod_r     <= '0;
         prod_vld_r <= 1'b0;
         sat        <= 1'b0;
      end else begin
         prod_vld_r <= consume;
         if (consume) begin
            prod_r <= {{DIM{1'b0}}, cur_data} * {{DIM{1'b0}}, dly_data};
            count  <= count_inc;
         end
         if (take_start) begin
            n_lat <= n_samples;
            count <= '0;
            acc   <= '0;
            sat   <= 1'b0;
         end else if (prod_vld_r && !sat) begin
            if (sum[ACC_W]) begin
               acc <= '1;
               sat <= 1'b1;
            end else begin
               acc <= sum[ACC_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_lag_accumulator.sv
// Directed bench for lag_accumulator: sums, stall gaps, backpressure, zero length,
// saturation and asynchronous reset, each with hand-computed expectations.
module tb_lag_accumulator;

   localparam int DIM   = 16;
   localparam int ACC_W = 32;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             clr_n = 1'b0;
   logic             stall = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] n_samples = '0;
   logic [DIM-1:0]   cur_data = '0;
   logic [DIM-1:0]   dly_data = '0;
   logic             busy, out_valid, out_sat;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lag_accumulator #(.DIM(DIM), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr_n(clr_n), .stall(stall), .start(start),
      .n_samples(n_samples), .cur_data(cur_data), .dly_data(dly_data),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_count(out_count), .out_sat(out_sat)
   );

   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      start = 1'b1;
      n_samples = n;
      wait_cycle();
      start = 1'b0;
   endtask

   task automatic send_pair(input logic [DIM-1:0] a, input logic [DIM-1:0] b);
      cur_data = a;
      dly_data = b;
      stall = 1'b0;
      wait_cycle();
      stall = 1'b1;
      cur_data = 16'hDEAD;
      dly_data = 16'hBEEF;
   endtask

   task automatic stall_cycle();
      stall = 1'b1;
      wait_cycle();
   endtask

   // Returns how many extra cycles were spent waiting for out_valid.
   task automatic wait_valid(output int waited);
      waited = 0;
      while (!out_valid && waited < 30) begin
         wait_cycle();
         waited++;
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      #12;
      vectors++;
      if ({busy, out_valid, out_sat} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 000", {busy, out_valid, out_sat});
      end
      vectors++;
      if (out_acc !== '0 || out_count !== '0) begin
         miscompares++;
         $display("FAIL reset_values: got acc=%0h count=%0d expected 0/0", out_acc, out_count);
      end
      wait_cycle();
      clr_n = 1'b1;
      wait_cycle();
   endtask

   task automatic test_basic_sum();
      int cycles, waited;
      do_start(4);
      cycles = 1;
      send_pair(3, 5);   cycles++;
      send_pair(2, 2);   cycles++;
      send_pair(1, 7);   cycles++;
      send_pair(10, 10); cycles++;
      vectors++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_drain: got busy=%b valid=%b expected 1/0", busy, out_valid);
      end
      wait_valid(waited);
      cycles += waited;
      vectors++;
      if (!out_valid || cycles != 6) begin
         miscompares++;
         $display("FAIL basic_latency: got valid=%b at cycle %0d expected 1 at 6", out_valid, cycles);
      end
      vectors++;
      if (out_acc !== 32'd126 || out_count !== 32'd4 || out_sat !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_result: got acc=%0d count=%0d sat=%b expected 126/4/0",
                  out_acc, out_count, out_sat);
      end
      out_ready = 1'b1;
      wait_cycle();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== 32'd126 || out_count !== 32'd4) begin
         miscompares++;
         $display("FAIL basic_idle: got valid=%b busy=%b acc=%0d count=%0d expected 0/0/126/4",
                  out_valid, busy, out_acc, out_count);
      end
   endtask

   task automatic test_stall_gaps();
      int cycles, waited;
      do_start(4);
      cycles = 1;
      send_pair(3, 5);   cycles++;
      stall_cycle();     cycles++;
      send_pair(2, 2);   cycles++;
      stall_cycle();     cycles++;
      stall_cycle();     cycles++;
      send_pair(1, 7);   cycles++;
      send_pair(10, 10); cycles++;
      wait_valid(waited);
      cycles += waited;
      vectors++;
      if (!out_valid || cycles != 9) begin
         miscompares++;
         $display("FAIL stall_latency: got valid=%b at cycle %0d expected 1 at 9", out_valid, cycles);
      end
      vectors++;
      if (out_acc !== 32'd126 || out_count !== 32'd4) begin
         miscompares++;
         $display("FAIL stall_result: got acc=%0d count=%0d expected 126/4", out_acc, out_count);
      end
      out_ready = 1'b1;
      wait_cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int waited;
      do_start(2);
      send_pair(6, 7);
      send_pair(1, 1);
      wait_valid(waited);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            start = 1'b1;
            n_samples = 9;
         end
         wait_cycle();
         start = 1'b0;
         vectors++;
         if (out_valid !== 1'b1 || busy !== 1'b0 || out_acc !== 32'd43 || out_count !== 32'd2) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got valid=%b busy=%b acc=%0d count=%0d expected 1/0/43/2",
                     i, out_valid, busy, out_acc, out_count);
         end
      end
      out_ready = 1'b1;
      wait_cycle();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== 32'd43 || out_count !== 32'd2) begin
         miscompares++;
         $display("FAIL bp_release: got valid=%b busy=%b acc=%0d count=%0d expected 0/0/43/2",
                  out_valid, busy, out_acc, out_count);
      end
   endtask

   task automatic test_zero_length();
      do_start(0);
      vectors++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || out_acc !== '0 || out_count !== '0) begin
         miscompares++;
         $display("FAIL zero_len: got valid=%b busy=%b acc=%0d count=%0d expected 1/0/0/0",
                  out_valid, busy, out_acc, out_count);
      end
      out_ready = 1'b1;
      wait_cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_saturation();
      int waited;
      do_start(3);
      for (int i = 0; i < 3; i++) send_pair(16'hFFFF, 16'hFFFF);
      wait_valid(waited);
      vectors++;
      if (!out_valid || out_acc !== 32'hFFFF_FFFF || out_sat !== 1'b1 || out_count !== 32'd3) begin
         miscompares++;
         $display("FAIL sat_result: got valid=%b acc=%0h sat=%b count=%0d expected 1/ffffffff/1/3",
                  out_valid, out_acc, out_sat, out_count);
      end
      out_ready = 1'b1;
      wait_cycle();
      out_ready = 1'b0;
      vectors++;
      if (out_sat !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_idle_keep: got %b expected 1", out_sat);
      end
      do_start(1);
      vectors++;
      if (out_sat !== 1'b0 || out_acc !== '0) begin
         miscompares++;
         $display("FAIL sat_clear: got sat=%b acc=%0h expected 0/0", out_sat, out_acc);
      end
      send_pair(2, 3);
      wait_valid(waited);
      vectors++;
      if (!out_valid || out_acc !== 32'd6 || out_sat !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_after: got valid=%b acc=%0d sat=%b expected 1/6/0", out_valid, out_acc, out_sat);
      end
      out_ready = 1'b1;
      wait_cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      int waited;
      do_start(8);
      send_pair(9, 9);
      send_pair(5, 5);
      #2;
      clr_n = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_acc !== '0 || out_count !== '0) begin
         miscompares++;
         $display("FAIL async_abort: got busy=%b valid=%b acc=%0d count=%0d expected 0/0/0/0",
                  busy, out_valid, out_acc, out_count);
      end
      wait_cycle();
      clr_n = 1'b1;
      wait_cycle();
      do_start(1);
      send_pair(4, 4);
      wait_valid(waited);
      vectors++;
      if (!out_valid || out_acc !== 32'd16 || out_count !== 32'd1) begin
         miscompares++;
         $display("FAIL async_restart: got valid=%b acc=%0d count=%0d expected 1/16/1",
                  out_valid, out_acc, out_count);
      end
      out_ready = 1'b1;
      wait_cycle();
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_sum();
      test_stall_gaps();
      test_backpressure();
      test_zero_length();
      test_saturation();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lag_accumulator.md
Name: lag_accumulator

Overview:
- Consumer end of the correlator delay path: takes the undelayed sample and the delay-line output for one lag channel each non-stalled cycle.
- Multiplies the two samples and accumulates the products over a programmed number of sample pairs.
- Presents the finished lag sum to the readout logic through a valid/ready handshake.
- One instance per lag, placed directly after the matching delay-line tap; shares that tap's stall.

Parameters:
- DIM, 16, sample width (unsigned), equal to the delay-line DIM.
- ACC_W, 48, accumulator width; must be >= 2*DIM.
- CNT_W, 32, sample counter width.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- stall  input  1  1 = no sample pair presented this cycle (same meaning as the delay-line stall).
- start  input  1  single-cycle pulse; begins an integration; honoured only in IDLE.
- n_samples  input  CNT_W  number of pairs to integrate; latched on an accepted start.
- cur_data  input  DIM  undelayed sample.
- dly_data  input  DIM  delay-line output for this lag.
- busy  output  1  1 in RUN or DRAIN.
- out_valid  output  1  1 in DONE.
- out_ready  input  1  readout accepts the result when out_valid & out_ready.
- out_acc  output  ACC_W  accumulated sum.
- out_count  output  CNT_W  pairs actually integrated.
- out_sat  output  1  sticky saturation flag for the current result.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE; acc, count, latched n, prod_r, prod_vld_r, out_sat cleared; busy=0; out_valid=0; out_acc=0; out_count=0. Release is synchronous to clk.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE + start: latch n_samples; clear acc, count and out_sat.
  - Next state is RUN, or DONE if n_samples==0. With n_samples==0, out_acc=0 and out_count=0.
- RUN: a pair is consumed on every cycle with stall=0.
  - prod_r <= cur_data*dly_data (2*DIM bits, unsigned); prod_vld_r <= 1; count <= count+1.
  - On a stall=1 cycle: prod_vld_r <= 0 and count holds.
- Accumulate stage: on every cycle with prod_vld_r=1, acc <= acc + zero-extended prod_r. This stage does not depend on stall.
- Saturation: if the sum carries out of ACC_W, acc <= all ones and out_sat <= 1. Once saturated, acc stays at all ones until the next start.
- End of integration: on the cycle that consumes pair number n (count becomes n), next state is DRAIN.
- DRAIN lasts exactly 1 cycle. It adds the final product and then goes to DONE.
- Latency: the last pair is consumed in cycle T; out_valid=1 from cycle T+2.
- DONE:
  - out_valid=1. out_acc, out_count and out_sat hold stable until the handshake.
  - The cycle with out_valid & out_ready goes to IDLE; out_valid=0 the following cycle.
  - out_acc, out_count and out_sat keep their values in IDLE until the next start.
- start outside IDLE is ignored: no restart, no effect on the latched n.
- stall during DRAIN or DONE has no effect.
- cur_data and dly_data are ignored outside RUN.
- Reset mid-RUN or mid-DONE aborts immediately to the reset values. No result is emitted.
- count never exceeds the latched n. No wrap-around is possible, because n is at most 2^CNT_W-1.

Test Plan:
- Basic sum: start with n=4; pairs (3,5),(2,2),(1,7),(10,10), no stall -> out_valid rises 2 cycles after the 4th pair; out_acc=126, out_count=4, out_sat=0.
- Stall gaps: same data and n=4, with stall=1 on 3 cycles interleaved -> out_acc=126, out_count=4; out_valid comes 3 cycles later than in the basic-sum case.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and outputs stay stable; a start pulse during that window is ignored; out_ready=1 -> IDLE on the next cycle.
- Zero length: start with n=0 -> DONE the next cycle, out_acc=0, out_count=0.
- Saturation (ACC_W=32, DIM=16): n=3, all pairs (0xFFFF,0xFFFF) -> out_acc=0xFFFFFFFF, out_sat=1; the next start clears out_sat.
- Async reset: assert clr_n=0 mid-RUN (after 2 of 8 pairs), between clock edges -> busy=0 and out_valid=0 immediately; after release a new start with n=1 and pair (4,4) gives out_acc=16.
